usb_rst_sequencer: RTL and testbench
====================================

# usb_rst_sequencer

Avalon-MM slave that sequences the reset of the external USB host controller chip, replacing the bare software-toggled reset PIO. It drives a timed active-low reset pulse, waits a settle interval, then waits for the chip's ready indication with a timeout. It reports done/timeout status and an optional interrupt to the Nios II. It sits on the lightweight peripheral bus beside the SPI/HPI bridge to the USB chip.

## Interface
Parameters:
- ASSERT_CYCLES, 500, reset-value of ASSERT_LEN register (10 us at 50 MHz)
- SETTLE_CYCLES, 50000, reset-value of SETTLE_LEN register (1 ms)
- TIMEOUT_CYCLES, 5000000, ready-wait timeout (100 ms), fixed
- CNT_W, 24, counter/length register width; must hold TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (read latency 0)
- usb_ready  in  1  chip ready/oscillator-OK, asynchronous to clk
- usb_rst_n  out  1  active-low reset to USB chip, registered
- irq  out  1  level interrupt, registered

## Operation
- Registers (write = chipselect & ~write_n):
  - 0 CTRL: wr bit0 GO (self-clearing, not stored), bit1 FORCE, bit2 IE. Rd {29'b0, IE, FORCE, busy}.
  - 1 STATUS: rd {29'b0, timeout, done, busy}; wr 1 to bit1/bit2 clears done/timeout (W1C).
  - 2 ASSERT_LEN: rd/wr, low CNT_W bits; upper bits read 0.
  - 3 SETTLE_LEN: rd/wr, same.
- States: IDLE, ASSERT, SETTLE, WAIT_RDY. busy = (state != IDLE).
- Reset values: state ASSERT, counter 0, ASSERT_LEN=ASSERT_CYCLES, SETTLE_LEN=SETTLE_CYCLES, FORCE=0, IE=0, done=0, timeout=0, usb_rst_n=0, irq=0. A full power-up sequence runs automatically after reset.
- On GO in IDLE with FORCE=0: latch ASSERT_LEN/SETTLE_LEN into working copies, clear counter, go ASSERT. GO while busy or with FORCE=1: ignored.
- ASSERT: usb_rst_n=0; after max(len,1) cycles go SETTLE, counter cleared.
- SETTLE: usb_rst_n=1; after SETTLE_LEN cycles go WAIT_RDY (len 0 → WAIT_RDY next cycle).
- WAIT_RDY: usb_ready via 2-flop synchronizer. Sync high → done=1, IDLE. Counter reaches TIMEOUT_CYCLES → timeout=1, IDLE. Both in the same cycle: done wins.
- FORCE=1: usb_rst_n=0 continuously. An in-progress sequence aborts to IDLE with no flag set. FORCE=0: usb_rst_n=1 in IDLE.
- irq = IE & (done | timeout), registered.
- W1C clear and flag set in the same cycle: set wins.
- Register writes during a sequence affect only the next sequence.
- Reset asserted mid-sequence: immediate return to reset values, restarting at ASSERT.

## Timing
- usb_rst_n, irq, and flags update on the clk edge after the causing event. irq follows a flag by 1 cycle.
- Auto sequence after reset deassert: usb_rst_n low for ASSERT_LEN cycles counted from the first clk edge after reset release.
- GO write at edge N: state ASSERT at N+1, usb_rst_n low from N+1 for exactly L cycles, high at N+1+L.
- usb_ready rise to done: 3 edges (2 sync + 1 FSM).
- Timeout: done/timeout set exactly TIMEOUT_CYCLES cycles after WAIT_RDY entry if usb_ready never rises.

## Test plan
- Power-up, ASSERT_CYCLES=4, SETTLE_CYCLES=3, usb_ready tied 1 → usb_rst_n low 4 cycles after reset, high for 3, done=1 ~3 cycles later; STATUS reads 0x2.
- Write ASSERT_LEN=10, SETTLE_LEN=0, IE=1, GO, usb_ready=1 → usb_rst_n low exactly 10 cycles; WAIT_RDY next cycle; done then irq=1; W1C 0x2 → irq=0 next cycle.
- TIMEOUT_CYCLES=20, usb_ready=0, GO → timeout=1 exactly 20 cycles after WAIT_RDY entry, done=0, busy=0.
- GO during ASSERT, and ASSERT_LEN write mid-sequence → pulse length unchanged; second GO has no effect.
- FORCE=1 during SETTLE → usb_rst_n=0 next edge, busy=0, no flags; FORCE=0 → usb_rst_n=1.
- Assert reset during WAIT_RDY; separately, W1C clear in the same cycle as done set → after reset, full sequence restarts with defaults; in the collision case, done reads 1.

Source files
------------

// File: rtl/usb_rst_if.sv
// Avalon-MM register bus between the Nios II fabric and the USB reset sequencer.
`timescale 1ns/1ps
interface usb_rst_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb_rst_sequencer.sv
// Sequences the external USB host chip reset: timed low pulse, settle delay, then a
// ready wait with timeout. Reports done/timeout status and a level interrupt.
`timescale 1ns/1ps
module usb_rst_sequencer #(
    parameter int ASSERT_CYCLES  = 500,
    parameter int SETTLE_CYCLES  = 50000,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int CNT_W          = 24
) (
    input  logic      clk,
    input  logic      reset,
    usb_rst_if.slave  bus,
    input  logic      usb_ready,
    output logic      usb_rst_n,
    output logic      irq
);
    // state    | meaning
    // S_IDLE   | sequence finished or aborted; chip held per FORCE
    // S_ASSERT | driving usb_rst_n low for the working ASSERT length
    // S_SETTLE | reset released, waiting the working SETTLE length
    // S_WAIT_RDY | waiting for synchronized usb_ready, bounded by timeout
    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SETTLE, S_WAIT_RDY} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] asrt_len, sett_len, asrt_wk, sett_wk;
    logic             force_en, ie, done, timeout;
    logic             rdy_meta, rdy_sync;
    logic             wr, wr_ctrl, wr_status, go, force_nxt;
    logic             set_done, set_to, go_take, busy;
    logic             unused_wdata;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr & (bus.address == 2'd0);
    assign wr_status = wr & (bus.address == 2'd1);
    assign go        = wr_ctrl & bus.writedata[0];
    // FORCE acts on the same edge that stores it, so abort and pin drive line up with the write
    assign force_nxt = wr_ctrl ? bus.writedata[1] : force_en;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign busy      = (state != S_IDLE);
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ASSERT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        set_done  = 1'b0;
        set_to    = 1'b0;
        go_take   = 1'b0;
        if (force_nxt && busy) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_nxt = cnt;
                    if (go && !force_nxt) begin
                        state_nxt = S_ASSERT;
                        cnt_nxt   = '0;
                        go_take   = 1'b1;
                    end
                end
                // a length of 0 behaves like 1 since cnt_inc >= 0 always holds
                S_ASSERT: begin
                    if (cnt_inc >= asrt_wk) begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt_inc >= sett_wk) begin
                        state_nxt = S_WAIT_RDY;
                        cnt_nxt   = '0;
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy_sync) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                        set_done  = 1'b1;
                    end else if (cnt_inc >= TIMEOUT_LIM) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                        set_to    = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asrt_len  <= CNT_W'(ASSERT_CYCLES);
            sett_len  <= CNT_W'(SETTLE_CYCLES);
            asrt_wk   <= CNT_W'(ASSERT_CYCLES);
            sett_wk   <= CNT_W'(SETTLE_CYCLES);
            force_en  <= 1'b0;
            ie        <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            irq       <= 1'b0;
            usb_rst_n <= 1'b0;
            rdy_meta  <= 1'b0;
            rdy_sync  <= 1'b0;
        end else begin
            rdy_meta <= usb_ready;
            rdy_sync <= rdy_meta;
            if (wr_ctrl) begin
                force_en <= bus.writedata[1];
                ie       <= bus.writedata[2];
            end
            if (wr && bus.address == 2'd2) asrt_len <= bus.writedata[CNT_W-1:0];
            if (wr && bus.address == 2'd3) sett_len <= bus.writedata[CNT_W-1:0];
            if (go_take) begin
                asrt_wk <= asrt_len;
                sett_wk <= sett_len;
            end
            if (set_done)                               done <= 1'b1;
            else if (wr_status && bus.writedata[1])     done <= 1'b0;
            if (set_to)                                 timeout <= 1'b1;
            else if (wr_status && bus.writedata[2])     timeout <= 1'b0;
            irq       <= ie & (done | timeout);
            usb_rst_n <= ~force_nxt & (state_nxt != S_ASSERT);
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = {29'b0, ie, force_en, busy};
            2'd1:    bus.readdata = {29'b0, timeout, done, busy};
            2'd2:    bus.readdata = 32'(asrt_len);
            default: bus.readdata = 32'(sett_len);
        endcase
    end
endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Self-checking bench for usb_rst_sequencer: register table, directed corner cases,
// and randomized sequences against an event-time model of the reset/ready timeline.
`timescale 1ns/1ps
module tb_usb_rst_sequencer;
    localparam int A_DEF = 4;
    localparam int S_DEF = 3;
    localparam int TO    = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic usb_ready = 1'b1;
    logic usb_rst_n, irq;
    int   tests = 0;
    int   fails = 0;

    usb_rst_if bus_if();

    usb_rst_sequencer #(
        .ASSERT_CYCLES(A_DEF), .SETTLE_CYCLES(S_DEF), .TIMEOUT_CYCLES(TO), .CNT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if.slave),
        .usb_ready(usb_ready), .usb_rst_n(usb_rst_n), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // call at a negedge; the write is sampled at the next posedge, returns at the following negedge
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.write_n    = 1'b1;
    endtask

    task automatic prep(input int l, input int s, input bit rdy);
        bus_write(2'd1, 32'h6);
        bus_write(2'd2, 32'(l));
        bus_write(2'd3, 32'(s));
        usb_ready = rdy;
        repeat (3) @(negedge clk);
    endtask

    // Expectations relative to the GO edge (k=0): low pulse max(L,1), settle max(S,1),
    // ready seen 2 edges after first sampled high, timeout TO edges after WAIT entry.
    task automatic run_seq(input int l, input int s, input bit ie_b, input int mode,
                           input int r, input bit disturb);
        int  la, sa, w, d, tend;
        bit  gets_done;
        la = (l < 1) ? 1 : l;
        sa = (s < 1) ? 1 : s;
        w  = la + sa;
        if (mode == 0)      d = w + 1;
        else if (mode == 1) d = (r + 2 > w + 1) ? r + 2 : w + 1;
        else                d = 1 << 30;
        gets_done = (d <= w + TO);
        tend = gets_done ? d : w + TO;
        bus_write(2'd0, {29'b0, ie_b, 1'b0, 1'b1});
        bus_if.address = 2'd1;
        #1;
        for (int k = 0; k <= tend + 2; k++) begin
            check("rst_n", usb_rst_n, k >= la);
            check("busy", bus_if.readdata[0], k < tend);
            if (!(disturb && (k == 3 || k == 4))) begin
                check("done", bus_if.readdata[1], gets_done && k >= tend);
                check("timeout", bus_if.readdata[2], !gets_done && k >= tend);
            end
            check("irq", irq, ie_b && k >= tend + 1);
            if (mode == 1 && k == r - 1) usb_ready = 1'b1;
            if (disturb && k == 2) begin
                bus_if.address = 2'd2; bus_if.writedata = 32'd3; bus_if.write_n = 1'b0;
            end
            if (disturb && k == 3) begin
                bus_if.address = 2'd0; bus_if.writedata = {29'b0, ie_b, 1'b0, 1'b1};
            end
            if (disturb && k == 4) begin
                bus_if.write_n = 1'b1; bus_if.address = 2'd1;
            end
            @(negedge clk);
            #1;
        end
    endtask

    // entered while reset is asserted and usb_ready is high
    task automatic powerup_check();
        bus_if.address = 2'd1;
        #1;
        check("rst_n_in_reset", usb_rst_n, 1'b0);
        check("irq_in_reset", irq, 1'b0);
        check("status_in_reset", bus_if.readdata, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            #1;
            check("pu_rst_n", usb_rst_n, k >= A_DEF);
            check("pu_busy", bus_if.readdata[0], k < A_DEF + S_DEF + 1);
            check("pu_done", bus_if.readdata[1], k >= A_DEF + S_DEF + 1);
            check("pu_irq", irq, 1'b0);
        end
        bus_if.address = 2'd2; #1; check("pu_assert_len", bus_if.readdata, 32'(A_DEF));
        bus_if.address = 2'd3; #1; check("pu_settle_len", bus_if.readdata, 32'(S_DEF));
        bus_if.address = 2'd0; #1; check("pu_ctrl", bus_if.readdata, 32'h0);
        bus_if.address = 2'd1; #1; check("pu_status", bus_if.readdata, 32'h2);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, s, mode, r, w;
        bit ie_b;
        vecs[0] = '{1'b0, 2'd1, 32'h0,        32'h2};
        vecs[1] = '{1'b1, 2'd2, 32'hABCDEF12, 32'h00CDEF12};
        vecs[2] = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h00FFFFFF};
        vecs[3] = '{1'b1, 2'd0, 32'h4,        32'h4};
        vecs[4] = '{1'b1, 2'd1, 32'h2,        32'h0};
        vecs[5] = '{1'b1, 2'd0, 32'h0,        32'h0};
        vecs[6] = '{1'b1, 2'd2, 32'h5,        32'h5};
        vecs[7] = '{1'b0, 2'd3, 32'h0,        32'h00FFFFFF};
        vecs[8] = '{1'b1, 2'd0, 32'h6,        32'h6};
        vecs[9] = '{1'b1, 2'd0, 32'h0,        32'h0};

        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd1;
        bus_if.writedata  = '0;
        repeat (3) @(negedge clk);
        powerup_check();

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else begin
                bus_if.address = vecs[i].addr;
                @(negedge clk);
            end
            bus_if.address = vecs[i].addr;
            #1;
            check($sformatf("vec%0d", i), bus_if.readdata, vecs[i].exp);
        end

        // long pulse, no settle, interrupt then W1C drop
        prep(10, 0, 1'b1);
        run_seq(10, 0, 1'b1, 0, 0, 1'b0);
        bus_write(2'd1, 32'h2);
        #1;
        check("w1c_irq_hold", irq, 1'b1);
        check("w1c_status", bus_if.readdata, 32'h0);
        @(negedge clk); #1;
        check("w1c_irq_drop", irq, 1'b0);
        bus_write(2'd0, 32'h0);

        // ready never arrives
        prep(2, 1, 1'b0);
        run_seq(2, 1, 1'b0, 2, 0, 1'b0);

        // GO and ASSERT_LEN write mid-pulse; new length only on the next sequence
        prep(8, 2, 1'b1);
        run_seq(8, 2, 1'b0, 0, 0, 1'b1);
        bus_write(2'd1, 32'h6);
        repeat (2) @(negedge clk);
        run_seq(3, 2, 1'b0, 0, 0, 1'b0);

        // FORCE during SETTLE
        prep(2, 10, 1'b0);
        bus_write(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h2);
        #1;
        check("force_rst_n", usb_rst_n, 1'b0);
        check("force_ctrl", bus_if.readdata, 32'h2);
        bus_if.address = 2'd1; #1;
        check("force_status", bus_if.readdata, 32'h0);
        repeat (25) @(negedge clk);
        #1;
        check("force_status_late", bus_if.readdata, 32'h0);
        check("force_rst_n_late", usb_rst_n, 1'b0);
        bus_write(2'd0, 32'h3);
        bus_if.address = 2'd0; #1;
        check("force_go_ignored", bus_if.readdata, 32'h2);
        check("force_go_rst_n", usb_rst_n, 1'b0);
        bus_write(2'd0, 32'h0);
        #1;
        check("unforce_rst_n", usb_rst_n, 1'b1);
        check("unforce_ctrl", bus_if.readdata, 32'h0);
        @(negedge clk); #1;
        check("unforce_idle", bus_if.readdata, 32'h0);

        // W1C in the same edge that sets done
        prep(1, 1, 1'b1);
        bus_write(2'd0, 32'h1);
        repeat (2) @(negedge clk);
        bus_write(2'd1, 32'h2);
        #1;
        check("collide_status", bus_if.readdata, 32'h2);

        for (int it = 0; it < 14; it++) begin
            l    = $urandom_range(0, 12);
            s    = $urandom_range(0, 6);
            ie_b = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            w    = ((l < 1) ? 1 : l) + ((s < 1) ? 1 : s);
            r    = $urandom_range(1, w + 22);
            prep(l, s, mode == 0);
            run_seq(l, s, ie_b, mode, r, 1'b0);
            bus_write(2'd0, 32'h0);
        end

        // reset during WAIT_RDY returns to defaults and reruns power-up
        prep(2, 2, 1'b0);
        bus_write(2'd0, 32'h5);
        bus_if.address = 2'd1;
        repeat (8) @(negedge clk);
        #1;
        check("pre_reset_busy", bus_if.readdata, 32'h1);
        reset = 1'b1;
        #1;
        check("async_rst_n", usb_rst_n, 1'b0);
        check("async_status", bus_if.readdata, 32'h1);
        usb_ready = 1'b1;
        powerup_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
